// File: rtl/sr_bank_pkg.sv
// Shared encodings for the SR status-bank arbiter: FSM states and set/clear op codes.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/sr_cell.sv
// One SR status bit, async clear to 0; s=r=1 is never presented by the arbiter.
// Latency 1 clk from s/r to q; no backpressure.
module sr_cell (
    input  logic clk,
    input  logic clr,
    input  logic s,
    input  logic r,
    output logic q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= 1'b0;
        end else begin
            case ({s, r})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin sequencer driving one set/clear pulse per op into a bank of SR cells.
// gnt 1 clk after the arbitration edge, 1 op per 3 clks; losers hold req until granted.
module sr_bank_arbiter
    import sr_bank_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_op,
    input  logic [N_REQ*IW-1:0] req_idx,
    output logic [N_REQ-1:0]    gnt,
    output logic                err,
    output logic                busy,
    output logic [WIDTH-1:0]    q
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [IW:0] WLIM = (IW+1)'(WIDTH);

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win_id;
    logic              win_op;
    logic [IW-1:0]     win_idx;
    logic [PW-1:0]     pick;
    logic              pick_vld;
    logic [PW:0]       cand;
    logic              in_range;
    logic [WIDTH-1:0]  s, r;

    // First active requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = pick_vld ? ST_DRIVE : ST_IDLE;
            ST_DRIVE: state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Winner's op is captured once; later changes on its inputs are ignored.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr     <= '0;
            win_id  <= '0;
            win_op  <= OP_CLR;
            win_idx <= '0;
        end else if (state == ST_IDLE && pick_vld) begin
            win_id  <= pick;
            win_op  <= req_op[pick];
            win_idx <= req_idx[pick*IW +: IW];
        end else if (state == ST_ACK) begin
            ptr <= (win_id == PW'(N_REQ-1)) ? '0 : win_id + PW'(1);
        end
    end

    assign in_range = ({1'b0, win_idx} < WLIM);

    always_comb begin
        gnt  = '0;
        err  = 1'b0;
        busy = 1'b0;
        s    = '0;
        r    = '0;
        case (state)
            ST_DRIVE: begin
                busy = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    if (in_range && win_idx == IW'(i)) begin
                        s[i] = (win_op == OP_SET);
                        r[i] = (win_op == OP_CLR);
                    end
                end
            end
            ST_ACK: begin
                busy        = 1'b1;
                gnt[win_id] = 1'b1;
                err         = !in_range;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        sr_cell u_cell (
            .clk (clk),
            .clr (clr),
            .s   (s[g]),
            .r   (r[g]),
            .q   (q[g])
        );
    end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter: directed ops push expected {gnt,err,q},
// monitors pop and compare on every gnt pulse.
module tb_sr_bank_arbiter;
    import sr_bank_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req, req_op;
    logic [11:0] req_idx;
    logic [3:0]  gnt;
    logic        err, busy;
    logic [7:0]  q;

    logic [3:0]  req6, op6;
    logic [11:0] idx6;
    logic [3:0]  gnt6;
    logic        err6, busy6;
    logic [5:0]  q6;

    sr_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .clr(clr), .req(req), .req_op(req_op), .req_idx(req_idx),
        .gnt(gnt), .err(err), .busy(busy), .q(q)
    );

    sr_bank_arbiter #(.N_REQ(4), .WIDTH(6)) dut6 (
        .clk(clk), .clr(clr), .req(req6), .req_op(op6), .req_idx(idx6),
        .gnt(gnt6), .err(err6), .busy(busy6), .q(q6)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic       err;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    exp_t sb6[$];
    int   gnt_c[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    logic [7:0] qm;
    logic [5:0] qm6;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (gnt !== 4'b0) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_gnt: got %b expected none", gnt);
            end else begin
                e = sb.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("err", 32'(err), 32'(e.err));
                chk("q",   32'(q),   32'(e.q));
                gnt_c.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin : mon6
        exp_t e;
        if (gnt6 !== 4'b0) begin
            if (sb6.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_gnt6: got %b expected none", gnt6);
            end else begin
                e = sb6.pop_front();
                chk("gnt6", 32'(gnt6),       32'(e.gnt));
                chk("err6", 32'(err6),       32'(e.err));
                chk("q6",   32'({2'b0, q6}), 32'(e.q));
            end
        end
    end

    task automatic issue(input int i, input logic op, input logic [2:0] idx);
        exp_t e;
        req_op[i] = op;
        req_idx[i*3 +: 3] = idx;
        req[i] = 1'b1;
        qm[idx] = op;
        e.gnt = 4'b0001 << i;
        e.err = 1'b0;
        e.q   = qm;
        sb.push_back(e);
    endtask

    task automatic issue6(input int i, input logic op, input logic [2:0] idx);
        exp_t e;
        op6[i] = op;
        idx6[i*3 +: 3] = idx;
        req6[i] = 1'b1;
        if (idx < 3'd6) qm6[idx] = op;
        e.gnt = 4'b0001 << i;
        e.err = (idx >= 3'd6);
        e.q   = {2'b0, qm6};
        sb6.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || sb6.size() > 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0 || sb6.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d/%0d grants still outstanding, expected 0", sb.size(), sb6.size());
            sb.delete();
            sb6.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        qm  = '0;
        qm6 = '0;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1;
        req = '0; req_op = '0; req_idx = '0;
        req6 = '0; op6 = '0; idx6 = '0;
        qm = '0; qm6 = '0;
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i] === 1'b1)  req[i]  = 1'b0;
                    if (gnt6[i] === 1'b1) req6[i] = 1'b0;
                end
            end
        join_none

        #12;
        chk("rst_q",    32'(q),    32'h0);
        chk("rst_gnt",  32'(gnt),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err",  32'(err),  32'h0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-DRIVE aborts the op; held req is served after release.
        issue(1, OP_SET, 3'd3);
        @(posedge clk);
        #2;
        chk("drive_busy", 32'(busy), 32'h1);
        clr = 1'b1;
        #1;
        chk("abort_q",    32'(q),    32'h0);
        chk("abort_gnt",  32'(gnt),  32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        clr = 1'b0;
        drain();

        // Single set / clear, then idempotent repeats.
        do_reset();
        issue(0, OP_SET, 3'd5); drain();
        issue(0, OP_CLR, 3'd5); drain();
        issue(0, OP_CLR, 3'd5); drain();
        issue(0, OP_SET, 3'd5); drain();
        issue(0, OP_SET, 3'd5); drain();

        // Requester drops req right after the latch edge.
        issue(1, OP_SET, 3'd6);
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        drain();
        chk("early_drop_q", 32'(q), 32'h60);

        // All four held: grants 0,1,2,3 three cycles apart.
        do_reset();
        gnt_c.delete();
        for (int i = 0; i < 4; i++) issue(i, OP_SET, 3'(i));
        drain();
        chk("rr_count", 32'(gnt_c.size()), 32'd4);
        for (int k = 1; k < 4 && k < gnt_c.size(); k++)
            chk("rr_spacing", 32'(gnt_c[k] - gnt_c[k-1]), 32'd3);

        // Pointer wrap: ptr=3 after serving req[2]; then 3 before 0, leaving ptr=1.
        do_reset();
        issue(2, OP_SET, 3'd2); drain();
        issue(3, OP_SET, 3'd7);
        issue(0, OP_CLR, 3'd2);
        drain();
        issue(1, OP_SET, 3'd1);
        issue(0, OP_SET, 3'd0);
        drain();

        // Out-of-range index on the WIDTH=6 instance.
        do_reset();
        issue6(2, OP_SET, 3'd1); drain();
        issue6(2, OP_SET, 3'd7); drain();
        issue6(2, OP_CLR, 3'd6); drain();
        chk("oor_q6", 32'({2'b0, q6}), 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
